// File: rtl/ftdi_bridge_pkg.sv
// Shared FSM encoding and timing floors for the FT245-style asynchronous FIFO bridge.
package ftdi_bridge_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_LOW   = 3'd1;
  localparam logic [2:0] WR_SETUP = 3'd2;
  localparam logic [2:0] WR_LOW   = 3'd3;
  localparam logic [2:0] TURN     = 3'd4;

  localparam int MIN_PULSE = 2;
  localparam int MIN_TURN  = 3;

  function automatic int atLeast(input int value, input int minVal);
    return (value < minVal) ? minVal : value;
  endfunction

endpackage

// File: rtl/fifo_sync_w.sv
// Single-clock first-word-fall-through FIFO; pointers carry one extra wrap bit for full/empty.
module fifo_sync_w #(
  parameter int pWidth = 8,
  parameter int pDepth = 16
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iPush,
  input  logic [pWidth-1:0] iData,
  output logic              oFull,
  input  logic              iPop,
  output logic [pWidth-1:0] oData,
  output logic              oEmpty
);

  localparam int AW = $clog2(pDepth);

  logic [pWidth-1:0] mem [pDepth];
  logic [AW:0]       wrPtr;
  logic [AW:0]       rdPtr;
  logic              doPush;
  logic              doPop;

  assign oEmpty = (wrPtr == rdPtr);
  assign oFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPush = iPush && !oFull;
  assign doPop  = iPop && !oEmpty;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge iClk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= iData;
  end

  // Head word is forced to zero while empty so the read port is clean after reset.
  assign oData = oEmpty ? '0 : mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/ftdi_bridge_async.sv
// Bridge between FPGA word FIFOs and an FT245 asynchronous byte FIFO interface.
// Optional send-immediate flush pulse on oSiwu is built only with FTDI_SIWU_FLUSH_EN.
module ftdi_bridge_async
  import ftdi_bridge_pkg::*;
#(
  parameter int pWordBytes   = 1,
  parameter int pTxFifoDepth = 16,
  parameter int pRxFifoDepth = 16,
  parameter int pRdPulse     = 4,
  parameter int pWrPulse     = 4,
  parameter int pTurnaround  = 3,
  parameter int pSiwuIdle    = 1024
) (
  input  logic                    iClk,
  input  logic                    iRst_n,
  input  logic                    iTxEn,
  output logic                    oTxFull,
  input  logic [8*pWordBytes-1:0] iTxData,
  input  logic                    iRxEn,
  output logic                    oRxEmpty,
  output logic [8*pWordBytes-1:0] oRxData,
  inout  wire  [7:0]              ioFifoData,
  input  logic                    iRxF_n,
  input  logic                    iTxE_n,
  output logic                    oRx_n,
  output logic                    oTx_n,
  output logic                    oSiwu
);

  localparam int W      = 8 * pWordBytes;
  localparam int RD_P   = atLeast(pRdPulse, MIN_PULSE);
  localparam int WR_P   = atLeast(pWrPulse, MIN_PULSE);
  localparam int TURN_P = atLeast(pTurnaround, MIN_TURN);
  localparam logic [15:0] RD_LAST   = 16'(RD_P - 1);
  localparam logic [15:0] WR_LAST   = 16'(WR_P - 1);
  localparam logic [15:0] TURN_LAST = 16'(TURN_P - 1);

  if (pWordBytes < 1 || pWordBytes > 4 || pTxFifoDepth < 2 || pRxFifoDepth < 2 ||
      pSiwuIdle < 1) begin : gBadParam
    $error("ftdi_bridge_async: illegal parameter value");
  end

  logic [2:0]   state;
  logic [15:0]  cnt;
  logic         lastTx;
  logic [1:0]   rxfSync;
  logic [1:0]   txeSync;
  logic [W-1:0] txShift;
  logic [2:0]   txLeft;
  logic [W-1:0] rxAsm;
  logic [W-1:0] rxWord;
  logic [2:0]   rxCnt;

  logic         txFifoEmpty;
  logic         txFifoPop;
  logic [W-1:0] txFifoData;
  logic         rxFifoFull;
  logic         rxFifoPush;

  logic txBusy, rxElig, txElig, goRx, goTx, lastRd, lastWr, busDrive, siwuBusy;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rxfSync <= 2'b11;
      txeSync <= 2'b11;
    end else begin
      rxfSync <= {rxfSync[0], iRxF_n};
      txeSync <= {txeSync[0], iTxE_n};
    end
  end

  fifo_sync_w #(.pWidth(W), .pDepth(pTxFifoDepth)) uTxFifo (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iPush  (iTxEn),
    .iData  (iTxData),
    .oFull  (oTxFull),
    .iPop   (txFifoPop),
    .oData  (txFifoData),
    .oEmpty (txFifoEmpty)
  );

  fifo_sync_w #(.pWidth(W), .pDepth(pRxFifoDepth)) uRxFifo (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iPush  (rxFifoPush),
    .iData  (rxWord),
    .oFull  (rxFifoFull),
    .iPop   (iRxEn),
    .oData  (oRxData),
    .oEmpty (oRxEmpty)
  );

  assign txBusy = (txLeft != 3'd0);
  assign rxElig = !rxfSync[1] && !rxFifoFull;
  assign txElig = !txeSync[1] && (txBusy || !txFifoEmpty) && !siwuBusy;
  // On a tie the side not served last wins; lastTx=1 after reset so Rx goes first.
  assign goRx   = rxElig && (!txElig || lastTx);
  assign goTx   = txElig && !goRx;
  assign lastRd = (state == RD_LOW) && (cnt == RD_LAST);
  assign lastWr = (state == WR_LOW) && (cnt == WR_LAST);

  assign txFifoPop  = (state == IDLE) && goTx && !txBusy;
  assign rxFifoPush = lastRd && (rxCnt == 3'(pWordBytes - 1));

  always_comb begin
    rxWord = rxAsm;
    for (int b = 0; b < pWordBytes; b++) begin
      if (rxCnt == 3'(b)) rxWord[b*8 +: 8] = ioFifoData;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      lastTx <= 1'b1;
      txLeft <= '0;
      rxCnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (goRx) begin
            state  <= RD_LOW;
            lastTx <= 1'b0;
          end else if (goTx) begin
            state  <= WR_SETUP;
            lastTx <= 1'b1;
            if (!txBusy) txLeft <= 3'(pWordBytes);
          end
        end
        RD_LOW: begin
          if (lastRd) begin
            state <= TURN;
            cnt   <= '0;
            rxCnt <= rxFifoPush ? 3'd0 : rxCnt + 3'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WR_SETUP: begin
          state <= WR_LOW;
          cnt   <= '0;
        end
        WR_LOW: begin
          if (lastWr) begin
            state  <= TURN;
            cnt    <= '0;
            txLeft <= txLeft - 3'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        TURN: begin
          if (cnt == TURN_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte lanes carry no reset; validity is tracked by txLeft and rxCnt.
  always_ff @(posedge iClk) begin
    if (txFifoPop)   txShift <= txFifoData;
    else if (lastWr) txShift <= txShift >> 8;
    if (lastRd)      rxAsm   <= rxWord;
  end

  assign busDrive   = (state == WR_SETUP) || (state == WR_LOW);
  assign ioFifoData = busDrive ? txShift[7:0] : 8'bz;
  assign oRx_n      = (state != RD_LOW);
  assign oTx_n      = (state != WR_LOW);

`ifdef FTDI_SIWU_FLUSH_EN
  localparam int IW = $clog2(pSiwuIdle + 1);

  logic [IW-1:0] idleCnt;
  logic [15:0]   siwuCnt;
  logic          siwuArmed;
  logic          siwuActive;
  logic          siwuStart;

  // Fires once per burst after pSiwuIdle quiet cycles; queued Tx data holds it off.
  assign siwuStart = siwuArmed && txFifoEmpty && !txBusy &&
                     (idleCnt >= IW'(pSiwuIdle - 1)) &&
                     (state != WR_SETUP) && (state != WR_LOW);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      idleCnt    <= '0;
      siwuCnt    <= '0;
      siwuArmed  <= 1'b0;
      siwuActive <= 1'b0;
    end else begin
      if (state == WR_LOW) begin
        idleCnt   <= '0;
        siwuArmed <= 1'b1;
      end else if (idleCnt != IW'(pSiwuIdle)) begin
        idleCnt <= idleCnt + 1'b1;
      end
      if (siwuActive) begin
        if (siwuCnt == WR_LAST) siwuActive <= 1'b0;
        else                    siwuCnt    <= siwuCnt + 16'd1;
      end else if (siwuStart) begin
        siwuActive <= 1'b1;
        siwuCnt    <= '0;
        siwuArmed  <= 1'b0;
      end
    end
  end

  assign siwuBusy = siwuActive;
  assign oSiwu    = !siwuActive;
`else
  assign siwuBusy = 1'b0;
  assign oSiwu    = 1'b1;
`endif

endmodule
